pb_event_queue: RTL and testbench



---
 rtl/pb_event_queue.sv | 165 ++++++++++++++++
 tb/tb_pb_event_queue.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_event_queue.sv
// Pushbutton front end: synchronize and debounce each button, turn each
// accepted press into one event, and queue button codes in a small FWFT FIFO.
module pb_event_queue #(
    parameter int N              = 21,
    parameter int DEBOUNCE_TICKS = 3,
    parameter int DEPTH          = 4
) (
    input  logic         hz100,
    input  logic         reset,
    input  logic [N-1:0] pb,
    output logic         evt_valid,
    output logic [4:0]   evt_code,
    input  logic         evt_ready,
    output logic [N-1:0] pressed,
    output logic         overflow
);

    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [NW-1:0] COUNT_FULL = NW'(DEPTH);

    logic [N-1:0] s1_reg;
    logic [N-1:0] s2_reg;
    logic [N-1:0] stable_reg;
    logic [N-1:0] stable_next;
    logic [N-1:0] rise;
    logic [N-1:0] pend_reg;
    logic [N-1:0] pend_next;
    logic [N-1:0] pend_clr;
    logic         overflow_reg;
    logic         overflow_next;

    logic [4:0]    mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [NW-1:0] count_reg;
    logic [NW-1:0] count_next;

    logic       push_any;
    logic [4:0] push_idx;
    logic       push_en;
    logic       pop_en;

    // Two-flop synchronizer and debounced level register
    always_ff @(posedge hz100) begin
        if (reset) begin
            s1_reg     <= '0;
            s2_reg     <= '0;
            stable_reg <= '0;
        end else begin
            s1_reg     <= pb;
            s2_reg     <= s1_reg;
            stable_reg <= stable_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_debounce
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_next;
            logic          stable_bit_next;

            // Counter tracks consecutive samples disagreeing with the accepted level
            always_comb begin
                cnt_next        = cnt_reg;
                stable_bit_next = stable_reg[gi];
                if (s2_reg[gi] == stable_reg[gi]) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    stable_bit_next = s2_reg[gi];
                    cnt_next        = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge hz100) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign stable_next[gi] = stable_bit_next;
        end
    endgenerate

    // A press is the edge on which the accepted level goes 0->1
    assign rise = stable_next & ~stable_reg;

    // Lowest-index pending button wins the single push slot
    always_comb begin
        push_any = 1'b0;
        push_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                push_any = 1'b1;
                push_idx = 5'(i);
            end
        end
    end

    // Space is judged on the registered count; a same-cycle pop does not help
    assign push_en  = push_any && (count_reg < COUNT_FULL);
    assign pop_en   = (count_reg != '0) && evt_ready;
    assign pend_clr = push_en ? (N'(1) << push_idx) : '0;

    // A new press beats the clear of its own pending bit
    always_comb begin
        pend_next     = (pend_reg & ~pend_clr) | rise;
        overflow_next = overflow_reg | (|(rise & pend_reg & ~pend_clr));
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            pend_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            pend_reg     <= pend_next;
            overflow_reg <= overflow_next;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push_en, pop_en})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge hz100) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge hz100) begin
        if (push_en) begin
            mem_reg[wr_ptr_reg] <= push_idx;
        end
    end

    assign evt_valid = (count_reg != '0);
    assign evt_code  = evt_valid ? mem_reg[rd_ptr_reg] : 5'd0;
    assign pressed   = stable_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pb_event_queue.sv
// Bench for pb_event_queue: scenario tasks with inline checks against a
// queue-based reference model that is advanced once per clock edge.
module tb_pb_event_queue;

    localparam int N     = 21;
    localparam int DT    = 3;
    localparam int DEPTH = 4;

    logic         hz100 = 1'b0;
    logic         reset = 1'b1;
    logic         evt_ready = 1'b0;
    logic [N-1:0] pb = '0;
    logic         evt_valid;
    logic [4:0]   evt_code;
    logic [N-1:0] pressed;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    pb_event_queue #(.N(N), .DEBOUNCE_TICKS(DT), .DEPTH(DEPTH)) dut (
        .hz100     (hz100),
        .reset     (reset),
        .pb        (pb),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .pressed   (pressed),
        .overflow  (overflow)
    );

    always #5 hz100 = ~hz100;

    // Reference model state
    logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stable = '0, m_pend = '0;
    int           m_run [N];
    int           m_q [$];
    logic         m_ovf = 1'b0;
    logic         m_valid = 1'b0;
    logic [4:0]   m_code = '0;

    task automatic model_update();
        logic [N-1:0] rise;
        int push;
        int old_size;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_pend = '0; m_ovf = 1'b0;
            m_q.delete();
            for (int i = 0; i < N; i++) m_run[i] = 0;
        end else begin
            rise = '0;
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] == m_stable[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == DT) begin
                        m_stable[i] = m_s2[i];
                        m_run[i] = 0;
                        rise[i] = m_s2[i];
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = pb;
            old_size = m_q.size();
            push = -1;
            if (old_size < DEPTH)
                for (int i = N - 1; i >= 0; i--) if (m_pend[i]) push = i;
            if (evt_ready && old_size > 0) void'(m_q.pop_front());
            if (push >= 0) begin
                m_q.push_back(push);
                m_pend[push] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (rise[i]) begin
                    if (m_pend[i]) m_ovf = 1'b1;
                    m_pend[i] = 1'b1;
                end
            end
        end
        m_valid = (m_q.size() != 0);
        m_code  = (m_q.size() != 0) ? 5'(m_q[0]) : 5'd0;
    endtask

    // Drive inputs, take one edge, advance the model, land on the next negedge
    task automatic step(input logic [N-1:0] p, input logic r, input logic rst);
        pb = p;
        evt_ready = r;
        reset = rst;
        @(posedge hz100);
        model_update();
        @(negedge hz100);
    endtask

    task automatic test_reset();
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b1);
        checks++;
        if ({evt_valid, evt_code, pressed, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h expected 0", {evt_valid, evt_code, pressed, overflow});
        end
        step('0, 1'b0, 1'b0);
        checks++;
        if ({evt_valid, evt_code, pressed, overflow} !== {m_valid, m_code, m_stable, m_ovf}) begin
            errors++;
            $display("FAIL reset_model got %h expected %h", {evt_valid, evt_code, pressed, overflow}, {m_valid, m_code, m_stable, m_ovf});
        end
    endtask

    task automatic test_single_press();
        logic [N-1:0] p;
        p = '0;
        p[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(p, 1'b0, 1'b0);
            checks++;
            if (pressed[1] !== 1'(k >= 5)) begin
                errors++;
                $display("FAIL single_pressed k=%0d got %b expected %b", k, pressed[1], k >= 5);
            end
            checks++;
            if ({evt_valid, evt_code} !== ((k >= 6) ? {1'b1, 5'd1} : 6'd0)) begin
                errors++;
                $display("FAIL single_event k=%0d got %b/%0d", k, evt_valid, evt_code);
            end
        end
        step(p, 1'b1, 1'b0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got valid=%b expected 0", evt_valid);
        end
        for (int k = 1; k <= 5; k++) begin
            step(p, 1'b0, 1'b0);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_no_repeat k=%0d got valid=%b expected 0", k, evt_valid);
            end
        end
        for (int k = 1; k <= 8; k++) begin
            step('0, 1'b0, 1'b0);
            checks++;
            if ({evt_valid, pressed[1]} !== {1'b0, 1'(k < 5)}) begin
                errors++;
                $display("FAIL single_release k=%0d got valid=%b pressed=%b", k, evt_valid, pressed[1]);
            end
        end
    endtask

    task automatic test_glitch();
        logic [N-1:0] p;
        p = '0;
        p[0] = 1'b1;
        step(p, 1'b0, 1'b0);
        step(p, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step('0, 1'b0, 1'b0);
            checks++;
            if ({evt_valid, pressed[0]} !== 2'b00) begin
                errors++;
                $display("FAIL glitch_short k=%0d got valid=%b pressed=%b expected 0/0", k, evt_valid, pressed[0]);
            end
        end
        for (int k = 0; k < 3; k++) step(p, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step('0, 1'b0, 1'b0);
            checks++;
            if ({evt_valid, evt_code, pressed, overflow} !== {m_valid, m_code, m_stable, m_ovf}) begin
                errors++;
                $display("FAIL glitch_model k=%0d got %h expected %h", k, {evt_valid, evt_code, pressed, overflow}, {m_valid, m_code, m_stable, m_ovf});
            end
        end
        checks++;
        if ({evt_valid, evt_code} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL glitch_accept got %b/%0d expected 1/0", evt_valid, evt_code);
        end
        step('0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            step('0, 1'b0, 1'b0);
            checks++;
            if (evt_valid !== 1'b0) begin
                errors++;
                $display("FAIL glitch_single k=%0d got valid=%b expected 0", k, evt_valid);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [N-1:0] p;
        int got [$];
        int first_k;
        first_k = -1;
        p = '0;
        p[7] = 1'b1; p[2] = 1'b1; p[19] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step((k <= 10) ? p : '0, 1'b1, 1'b0);
            checks++;
            if ({evt_valid, evt_code, pressed, overflow} !== {m_valid, m_code, m_stable, m_ovf}) begin
                errors++;
                $display("FAIL simul_model k=%0d got %h expected %h", k, {evt_valid, evt_code, pressed, overflow}, {m_valid, m_code, m_stable, m_ovf});
            end
            if (evt_valid) begin
                if (first_k < 0) first_k = k;
                got.push_back(int'(evt_code));
            end
        end
        checks++;
        if (got.size() != 3 || got[0] != 2 || got[1] != 7 || got[2] != 19 || first_k != 6) begin
            errors++;
            $display("FAIL simul_order got %p first at %0d expected '{2,7,19} first at 6", got, first_k);
        end
    endtask

    task automatic test_full_overflow();
        logic [N-1:0] p;
        int got [$];
        for (int b = 0; b <= 5; b++) begin
            p = '0;
            p[(b == 5) ? 4 : b] = 1'b1;
            for (int k = 0; k < int'($urandom_range(9, 6)); k++) step(p, 1'b0, 1'b0);
            for (int k = 0; k < 7; k++) begin
                step('0, 1'b0, 1'b0);
                checks++;
                if ({evt_valid, evt_code, pressed, overflow} !== {m_valid, m_code, m_stable, m_ovf}) begin
                    errors++;
                    $display("FAIL full_model b=%0d got %h expected %h", b, {evt_valid, evt_code, pressed, overflow}, {m_valid, m_code, m_stable, m_ovf});
                end
            end
            if (b == 4) begin
                checks++;
                if ({evt_valid, evt_code, overflow} !== {1'b1, 5'd0, 1'b0}) begin
                    errors++;
                    $display("FAIL full_no_overflow got %b/%0d ovf=%b expected 1/0 ovf=0", evt_valid, evt_code, overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_overflow got %b expected 1", overflow);
        end
        for (int k = 0; k < 10; k++) begin
            if (evt_valid) got.push_back(int'(evt_code));
            step('0, 1'b1, 1'b0);
        end
        checks++;
        if (got.size() != 5 || got[0] != 0 || got[1] != 1 || got[2] != 2 || got[3] != 3 || got[4] != 4) begin
            errors++;
            $display("FAIL full_drain got %p expected '{0,1,2,3,4}", got);
        end
    endtask

    task automatic test_wrap();
        logic [N-1:0] p;
        int got [$];
        int want [$];
        logic prev_valid;
        prev_valid = 1'b0;
        for (int it = 0; it < 10; it++) begin
            p = '0;
            p[(it % 2 == 0) ? 3 : 5] = 1'b1;
            want.push_back((it % 2 == 0) ? 3 : 5);
            for (int k = 0; k < int'($urandom_range(8, 6)) + int'($urandom_range(8, 6)); k++) begin
                step((k < 6) ? p : '0, 1'b1, 1'b0);
                if (evt_valid) got.push_back(int'(evt_code));
                checks++;
                if (evt_valid && prev_valid) begin
                    errors++;
                    $display("FAIL wrap_depth it=%0d got two valid cycles expected at most one entry", it);
                end
                prev_valid = evt_valid;
            end
        end
        for (int k = 0; k < 8; k++) begin
            step('0, 1'b1, 1'b0);
            if (evt_valid) got.push_back(int'(evt_code));
        end
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL wrap_order got %p expected %p", got, want);
        end
    endtask

    task automatic test_mid_reset();
        logic [N-1:0] p;
        for (int b = 1; b <= 2; b++) begin
            p = '0;
            p[b] = 1'b1;
            for (int k = 0; k < 6; k++) step(p, 1'b0, 1'b0);
            for (int k = 0; k < 6; k++) step('0, 1'b0, 1'b0);
        end
        checks++;
        if ({evt_valid, evt_code} !== {1'b1, 5'd1}) begin
            errors++;
            $display("FAIL midrst_queued got %b/%0d expected 1/1", evt_valid, evt_code);
        end
        p = '0;
        p[6] = 1'b1;
        for (int k = 0; k < 3; k++) step(p, 1'b0, 1'b0);
        step(p, 1'b0, 1'b1);
        checks++;
        if ({evt_valid, evt_code, pressed, overflow} !== '0) begin
            errors++;
            $display("FAIL midrst_clear got %h expected 0", {evt_valid, evt_code, pressed, overflow});
        end
        for (int k = 1; k <= 8; k++) begin
            step(p, 1'b0, 1'b0);
            checks++;
            if ({evt_valid, evt_code} !== ((k >= 6) ? {1'b1, 5'd6} : 6'd0)) begin
                errors++;
                $display("FAIL midrst_repress k=%0d got %b/%0d", k, evt_valid, evt_code);
            end
        end
        for (int k = 0; k < 8; k++) step('0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [N-1:0] p;
        logic r;
        logic rst;
        p = '0;
        for (int k = 0; k < 500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ((i < 6) ? ($urandom_range(11) == 0) : ($urandom_range(99) == 0)) p[i] = ~p[i];
            end
            r = (k < 250) ? ($urandom_range(3) != 0) : ($urandom_range(5) == 0);
            rst = ($urandom_range(199) == 0);
            step((k < 480) ? p : '0, (k < 480) ? r : 1'b1, rst);
            checks++;
            if ({evt_valid, evt_code, pressed, overflow} !== {m_valid, m_code, m_stable, m_ovf}) begin
                errors++;
                $display("FAIL random_model k=%0d got %h expected %h", k, {evt_valid, evt_code, pressed, overflow}, {m_valid, m_code, m_stable, m_ovf});
            end
        end
    endtask

    initial begin
        @(negedge hz100);
        test_reset();
        test_single_press();
        test_glitch();
        test_simultaneous();
        test_full_overflow();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
